// File: rtl/dht11_reader.sv
// DHT11 single-wire transaction controller: start pulse, response and 40-bit frame
// timing on ticks from the divider output, then checksum and reading capture.
module dht11_reader #(
  parameter int unsigned TICK_BITS     = 12,
  parameter int unsigned START_TICKS   = 3600,
  parameter int unsigned BIT1_TICKS    = 10,
  parameter int unsigned TIMEOUT_TICKS = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tb_in,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec
);

  localparam logic [TICK_BITS-1:0] START_CNT   = TICK_BITS'(START_TICKS);
  localparam logic [TICK_BITS-1:0] BIT1_CNT    = TICK_BITS'(BIT1_TICKS);
  localparam logic [TICK_BITS-1:0] TIMEOUT_CNT = TICK_BITS'(TIMEOUT_TICKS);
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_RESP = 2'd1;
  localparam logic [1:0] ERR_BIT  = 2'd2;
  localparam logic [1:0] ERR_SUM  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_FINISH
  } state_t;

  state_t                r_state;
  logic [1:0]            r_tb_sync;
  logic                  r_tb_d;
  logic [1:0]            r_dht_sync;
  logic                  r_dht_d;
  logic [TICK_BITS-1:0]  r_cnt;
  logic [5:0]            r_idx;
  logic [39:0]           r_shift;
  logic                  r_oe;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [1:0]            r_err_code;
  logic [7:0]            r_hum_int;
  logic [7:0]            r_hum_dec;
  logic [7:0]            r_temp_int;
  logic [7:0]            r_temp_dec;

  logic                  w_tick;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_timeout;
  logic [7:0]            w_sum;

  assign w_tick    = r_tb_sync[1] & ~r_tb_d;
  assign w_rise    = r_dht_sync[1] & ~r_dht_d;
  assign w_fall    = ~r_dht_sync[1] & r_dht_d;
  assign w_timeout = (r_cnt >= TIMEOUT_CNT);
  assign w_sum     = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];

  // Transition branches clear the tick counter, overriding the default increment,
  // so edge decisions always see the pre-increment count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tb_sync  <= '0;
      r_tb_d     <= 1'b0;
      r_dht_sync <= '0;
      r_dht_d    <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
      r_hum_int  <= '0;
      r_hum_dec  <= '0;
      r_temp_int <= '0;
      r_temp_dec <= '0;
    end else begin
      r_tb_sync  <= {r_tb_sync[0], tb_in};
      r_tb_d     <= r_tb_sync[1];
      r_dht_sync <= {r_dht_sync[0], dht_in};
      r_dht_d    <= r_dht_sync[1];
      r_done     <= 1'b0;
      if (w_tick && (r_cnt != '1)) r_cnt <= r_cnt + TICK_BITS'(1);

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_START_LOW;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_oe       <= 1'b1;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
          end
        end
        S_START_LOW: begin
          if (r_cnt >= START_CNT) begin
            r_state <= S_RELEASE;
            r_cnt   <= '0;
            r_oe    <= 1'b0;
          end
        end
        S_RELEASE, S_RESP_LOW, S_RESP_HIGH: begin
          if ((r_state == S_RELEASE) && w_fall) begin
            r_state <= S_RESP_LOW;
            r_cnt   <= '0;
          end else if ((r_state == S_RESP_LOW) && w_rise) begin
            r_state <= S_RESP_HIGH;
            r_cnt   <= '0;
          end else if ((r_state == S_RESP_HIGH) && w_fall) begin
            r_state <= S_BIT_LOW;
            r_cnt   <= '0;
            r_idx   <= '0;
          end else if (w_timeout) begin
            r_state    <= S_FINISH;
            r_cnt      <= '0;
            r_oe       <= 1'b0;
            r_done     <= 1'b1;
            r_error    <= 1'b1;
            r_err_code <= ERR_RESP;
          end
        end
        S_BIT_LOW, S_BIT_HIGH: begin
          if ((r_state == S_BIT_LOW) && w_rise) begin
            r_state <= S_BIT_HIGH;
            r_cnt   <= '0;
          end else if ((r_state == S_BIT_HIGH) && w_fall) begin
            r_shift <= {r_shift[38:0], (r_cnt >= BIT1_CNT)};
            r_cnt   <= '0;
            if (r_idx == 6'd39) begin
              r_state <= S_CHECK;
            end else begin
              r_state <= S_BIT_LOW;
              r_idx   <= r_idx + 6'd1;
            end
          end else if (w_timeout) begin
            r_state    <= S_FINISH;
            r_cnt      <= '0;
            r_oe       <= 1'b0;
            r_done     <= 1'b1;
            r_error    <= 1'b1;
            r_err_code <= ERR_BIT;
          end
        end
        S_CHECK: begin
          if (w_sum == r_shift[7:0]) begin
            r_hum_int  <= r_shift[39:32];
            r_hum_dec  <= r_shift[31:24];
            r_temp_int <= r_shift[23:16];
            r_temp_dec <= r_shift[15:8];
          end else begin
            r_error    <= 1'b1;
            r_err_code <= ERR_SUM;
          end
          r_state <= S_FINISH;
          r_cnt   <= '0;
          r_done  <= 1'b1;
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_oe    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dht_oe   = r_oe;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign err_code = r_err_code;
  assign hum_int  = r_hum_int;
  assign hum_dec  = r_hum_dec;
  assign temp_int = r_temp_int;
  assign temp_dec = r_temp_dec;

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader: a behavioural sensor drives the line in step
// with the divider tick, and each step checks outputs against hand-derived values.
module tb_dht11_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tb_in = 1'b0;
  logic       start = 1'b0;
  logic       sens_line = 1'b1;
  logic       dht_in;
  logic       dht_oe, busy, done, error;
  logic [1:0] err_code;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int oe_ticks = 0;
  int rel_ticks = 0;
  logic done_d1 = 1'b0, done_d2 = 1'b0;
  logic busy_p1 = 1'b0, busy_p2 = 1'b0, oe_p2 = 1'b0;
  bit   ok;

  localparam logic [39:0] FRAME_GOOD = 40'h37_00_19_05_55;
  localparam logic [39:0] FRAME_BAD  = 40'h37_00_19_05_54;
  localparam logic [39:0] FRAME_NEW  = 40'h40_01_1A_02_5D;

  // Open-drain line: host pull-down wins, otherwise the sensor (or pull-up) level.
  assign dht_in = dht_oe ? 1'b0 : sens_line;

  dht11_reader dut (
    .clk      (clk),
    .reset    (reset),
    .tb_in    (tb_in),
    .start    (start),
    .dht_in   (dht_in),
    .dht_oe   (dht_oe),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code),
    .hum_int  (hum_int),
    .hum_dec  (hum_dec),
    .temp_int (temp_int),
    .temp_dec (temp_dec)
  );

  always #5 clk = ~clk;
  always @(negedge clk) tb_in <= ~tb_in;

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  always @(negedge clk) begin
    done_d1 <= done;
    done_d2 <= done_d1;
    if (done_d1) busy_p1 <= busy;
    if (done_d2) begin
      busy_p2 <= busy;
      oe_p2   <= dht_oe;
    end
  end

  always @(posedge tb_in) begin
    if (dht_oe) oe_ticks++;
    if (busy && !dht_oe && !done) rel_ticks++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic line_for(input logic v, input int n);
    sens_line = v;
    repeat (n) @(negedge tb_in);
  endtask

  task automatic wait_release(output bit got);
    bit saw;
    saw = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (dht_oe) saw = 1'b1;
      else if (saw) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int n, output bit got);
    got = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Sensor reply with edges on tb_in falls, so a high phase of n periods counts n ticks.
  task automatic send_frame(input logic [39:0] fr, input int hi0, input int hi1, input int cut_bit);
    @(negedge tb_in);
    line_for(1'b1, 4);
    line_for(1'b0, 16);
    line_for(1'b1, 16);
    for (int i = 0; i < 40; i++) begin
      line_for(1'b0, 10);
      if (i == cut_bit) begin
        sens_line = 1'b1;
        return;
      end
      line_for(1'b1, fr[39-i] ? hi1 : hi0);
    end
    line_for(1'b0, 10);
    sens_line = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_oe", 32'(dht_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h0);

    // Good frame; zeros high 9 ticks and ones high 10 ticks sit on the decode boundary.
    oe_ticks = 0;
    pulse_start();
    wait_release(ok);
    chk("good_release", 32'(ok), 32'd1);
    chk("good_oe_ticks", 32'(oe_ticks), 32'd3600);
    send_frame(FRAME_GOOD, 9, 10, -1);
    repeat (4) @(negedge clk);
    chk("good_done_cnt", 32'(done_cnt), 32'd1);
    chk("good_error", 32'(error), 32'd0);
    chk("good_hum_int", 32'(hum_int), 32'd55);
    chk("good_hum_dec", 32'(hum_dec), 32'd0);
    chk("good_temp_int", 32'(temp_int), 32'd25);
    chk("good_temp_dec", 32'(temp_dec), 32'd5);

    // Bad checksum with typical 5/14 tick high phases.
    repeat (10) @(negedge clk);
    pulse_start();
    wait_release(ok);
    chk("bad_release", 32'(ok), 32'd1);
    send_frame(FRAME_BAD, 5, 14, -1);
    repeat (4) @(negedge clk);
    chk("bad_done_cnt", 32'(done_cnt), 32'd2);
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_err_code", 32'(err_code), 32'd3);
    chk("bad_data_held", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37001905);

    // Silent sensor: response timeout in RELEASE.
    repeat (10) @(negedge clk);
    rel_ticks = 0;
    pulse_start();
    wait_release(ok);
    chk("silent_release", 32'(ok), 32'd1);
    wait_done(300, ok);
    chk("silent_done_seen", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    chk("silent_rel_ticks", 32'(rel_ticks), 32'd40);
    chk("silent_done_cnt", 32'(done_cnt), 32'd3);
    chk("silent_err_code", 32'(err_code), 32'd1);
    chk("silent_error", 32'(error), 32'd1);
    chk("silent_oe", 32'(dht_oe), 32'd0);

    // Line stuck high during bit 17: bit timeout.
    repeat (10) @(negedge clk);
    pulse_start();
    wait_release(ok);
    chk("stuck_release", 32'(ok), 32'd1);
    send_frame(FRAME_GOOD, 9, 10, 17);
    wait_done(200, ok);
    chk("stuck_done_seen", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    chk("stuck_done_cnt", 32'(done_cnt), 32'd4);
    chk("stuck_err_code", 32'(err_code), 32'd2);
    chk("stuck_data_held", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37001905);

    // Reset while in BIT_HIGH of bit 5: abort without a done pulse.
    repeat (10) @(negedge clk);
    pulse_start();
    wait_release(ok);
    chk("abort_release", 32'(ok), 32'd1);
    send_frame(FRAME_GOOD, 9, 10, 5);
    repeat (3) @(negedge tb_in);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_oe", 32'(dht_oe), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_done_cnt", 32'(done_cnt), 32'd4);

    // New transaction with start held high: completes, then re-triggers after FINISH.
    start = 1'b1;
    wait_release(ok);
    chk("new_release", 32'(ok), 32'd1);
    send_frame(FRAME_NEW, 9, 10, -1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("new_done_cnt", 32'(done_cnt), 32'd5);
    chk("new_error", 32'(error), 32'd0);
    chk("new_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h40011A02);
    chk("retrig_idle_busy", 32'(busy_p1), 32'd0);
    chk("retrig_busy", 32'(busy_p2), 32'd1);
    chk("retrig_oe", 32'(oe_p2), 32'd1);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("end_oe", 32'(dht_oe), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
